// File: rtl/cnn_window_sched.sv
// 3x3 sliding-window read sequencer: gates each window on the write pointer and the core being idle.
// Optional stall-cycle counter output when CNN_SCHED_PERF_EN is defined.
module cnn_window_sched #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int AW    = 10
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [AW-1:0] wr_addr,
  input  logic          core_bsy,
  output logic [AW-1:0] rd_addr,
  output logic          rd_en,
  output logic          strt,
  output logic          din_vld,
  output logic          win_last,
  output logic          frame_done
`ifdef CNN_SCHED_PERF_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);
  localparam int TW = $clog2(K + 1);
  localparam logic [AW-1:0] A0     = AW'((K-1)*IMG_W + (K-1));
  localparam logic [AW-1:0] A_LAST = AW'(IMG_W*IMG_H - 1);
  localparam logic [AW-1:0] C0     = AW'(K-1);
  localparam logic [AW-1:0] C_LAST = AW'(IMG_W-1);
  localparam logic [TW-1:0] T_LAST = TW'(K-1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        r_state, w_nxt;
  logic [AW-1:0] r_anchor, r_col;
  logic [TW-1:0] r_trow, r_tcol;
  logic          r_din_vld;
  logic          w_ready, w_last_tap, w_final;
  logic [AW-1:0] w_rback, w_cback;

  assign w_ready    = (r_anchor < wr_addr) && !core_bsy;
  assign w_last_tap = (r_trow == T_LAST) && (r_tcol == T_LAST);
  assign w_final    = (r_anchor == A_LAST);
  assign w_rback    = AW'(K-1) - AW'(r_trow);
  assign w_cback    = AW'(K-1) - AW'(r_tcol);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_anchor  <= A0;
      r_col     <= C0;
      r_trow    <= '0;
      r_tcol    <= '0;
      r_din_vld <= 1'b0;
    end else begin
      // RAM has one cycle of read latency; a clr still lets the last strobe through
      r_din_vld <= rd_en;
      r_state   <= w_nxt;
      if (clr) begin
        r_anchor <= A0;
        r_col    <= C0;
        r_trow   <= '0;
        r_tcol   <= '0;
      end else begin
        if (r_state == ISSUE) begin
          if (r_tcol == T_LAST) begin
            r_tcol <= '0;
            r_trow <= (r_trow == T_LAST) ? '0 : r_trow + 1'b1;
          end else begin
            r_tcol <= r_tcol + 1'b1;
          end
        end
        if (r_state == DRAIN && !w_final) begin
          if (r_col == C_LAST) begin
            r_anchor <= r_anchor + AW'(K);
            r_col    <= C0;
          end else begin
            r_anchor <= r_anchor + 1'b1;
            r_col    <= r_col + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ready) w_nxt = ISSUE;
      ISSUE:   if (w_last_tap) w_nxt = DRAIN;
      DRAIN:   w_nxt = w_final ? DONE : IDLE;
      DONE:    w_nxt = DONE;
      default: w_nxt = IDLE;
    endcase
    if (clr) w_nxt = IDLE;
  end

  always_comb begin
    rd_en      = (r_state == ISSUE);
    strt       = rd_en && (r_trow == '0) && (r_tcol == '0);
    win_last   = rd_en && w_final;
    rd_addr    = rd_en ? (r_anchor - w_rback * AW'(IMG_W) - w_cback) : '0;
    frame_done = (r_state == DRAIN) && w_final;
    din_vld    = r_din_vld;
  end

`ifdef CNN_SCHED_PERF_EN
  logic [15:0] r_stall;
  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      r_stall <= '0;
    else if (r_state == IDLE && !w_ready && r_stall != 16'hFFFF)
      r_stall <= r_stall + 1'b1;
  end
  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_cnn_window_sched.sv
// Scoreboard bench for cnn_window_sched; stall counter checked when CNN_SCHED_PERF_EN is defined.
module tb_cnn_window_sched;
  localparam int W = 28, H = 28, K = 3, AW = 10;

  logic          clk = 0, rst_n = 0, clr = 0, core_bsy = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr;
  logic          rd_en, strt, din_vld, win_last, frame_done;
`ifdef CNN_SCHED_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  cnn_window_sched #(.IMG_W(W), .IMG_H(H), .K(K), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_addr(wr_addr), .core_bsy(core_bsy),
    .rd_addr(rd_addr), .rd_en(rd_en), .strt(strt), .din_vld(din_vld),
    .win_last(win_last), .frame_done(frame_done)
`ifdef CNN_SCHED_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {int addr; bit strt; bit last; int anchor; int tap;} rd_t;
  rd_t q[$];
  int  n_pass = 0, n_tot = 0;
  int  strt_cnt = 0, fd_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
  endtask

  // Reference order: every valid anchor row by row, 9 taps row-major from top-left
  function automatic void push_frame();
    rd_t e;
    for (int r = K-1; r < H; r++)
      for (int c = K-1; c < W; c++)
        for (int t = 0; t < K*K; t++) begin
          e.anchor = r*W + c;
          e.addr   = (r - (K-1) + t/K)*W + (c - (K-1) + t%K);
          e.strt   = (t == 0);
          e.last   = (e.anchor == W*H-1);
          e.tap    = t;
          q.push_back(e);
        end
  endfunction

  // Monitor
  bit p_rd = 0, p_rstn = 0, p_clr = 0, p_final = 0, p_bsy = 0;
  int p_wr = 0;
  always @(negedge clk) begin : mon
    rd_t e;
    bit  f;
    f = 0;
    if (rd_en === 1'b1) begin
      if (q.size() == 0) chk("unexpected_rd", int'(rd_addr), -1);
      else begin
        e = q.pop_front();
        chk("rd_addr", int'(rd_addr), e.addr);
        chk("strt", int'(strt), int'(e.strt));
        chk("win_last", int'(win_last), int'(e.last));
        if (e.strt) chk("start_gate", int'(p_wr > e.anchor && !p_bsy), 1);
        f = e.last && (e.tap == K*K-1);
      end
    end else if (strt === 1'b1 || win_last === 1'b1) begin
      chk("strobe_without_rd", int'(strt | win_last), 0);
    end
    if (din_vld === 1'b1 || (p_rd && p_rstn)) chk("din_vld", int'(din_vld), int'(p_rd && p_rstn));
    if (frame_done === 1'b1 || (p_final && p_rstn && !p_clr))
      chk("frame_done", int'(frame_done), int'(p_final && p_rstn && !p_clr));
    if (strt === 1'b1) strt_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    p_rd = (rd_en === 1'b1); p_rstn = rst_n; p_clr = clr; p_final = f;
    p_wr = int'(wr_addr); p_bsy = core_bsy;
  end

  task automatic wait_strt(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (strt !== 1'b1 && n < 200);
    chk(nm, int'(strt), 1);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_rd_en"}, int'(rd_en), 0);
    chk({nm, "_strt"}, int'(strt), 0);
    chk({nm, "_din_vld"}, int'(din_vld), 0);
    chk({nm, "_win_last"}, int'(win_last), 0);
    chk({nm, "_frame_done"}, int'(frame_done), 0);
    chk({nm, "_rd_addr"}, int'(rd_addr), 0);
  endtask

  initial begin
    int n, w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");

    // First windows with data fully written
    push_frame();
    @(posedge clk); #1 rst_n = 1; wr_addr = 10'd784;
    @(negedge clk); chk("idle_cycle0_rd_en", int'(rd_en), 0);
    @(negedge clk); chk("strt_cycle1", int'(strt), 1); chk("first_rd_addr", int'(rd_addr), 0);
    n = 0;
    do begin @(negedge clk); n++; end while (strt !== 1'b1 && n < 50);
    chk("window_period", n, 11);

    // clr during tap 4 of the third window
    wait_strt("third_window_strt");
    repeat (4) @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0; wr_addr = 10'd58; q.delete(); push_frame();
    @(negedge clk);
    chk("trailing_din_vld_after_clr", int'(din_vld), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      n += int'(rd_en);
    end
    chk("stall_no_rd", n, 0);
    @(posedge clk); #1 wr_addr = 10'd59;
    @(negedge clk); chk("stall_release_rd_en", int'(rd_en), 0);
`ifdef CNN_SCHED_PERF_EN
    chk("stall_cnt", int'(stall_cnt), 20);
`endif
    @(negedge clk); chk("strt_after_wr_change", int'(strt), 1);
    chk("restart_rd_addr", int'(rd_addr), 0);

    // core_bsy raised mid-ISSUE must not abort the window, then defers the next one
    @(posedge clk); #1 core_bsy = 1; wr_addr = 10'd784;
    n = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); n += int'(rd_en); end
    chk("bsy_mid_issue_reads", n, 8);
    @(posedge clk); #1 core_bsy = 0;
    @(negedge clk); chk("bsy_release_rd_en", int'(rd_en), 0);
    @(negedge clk); chk("strt_after_bsy", int'(strt), 1);
    chk("second_anchor_rd_addr", int'(rd_addr), 1);

    // Reset pulse mid-ISSUE
    repeat (2) @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1; wr_addr = '0; q.delete(); push_frame();
    strt_cnt = 0; fd_cnt = 0;
    @(negedge clk); chk_quiet("after_rst_pulse");

    // Full frame under random write progress and core busy
    n = 0;
    while (fd_cnt == 0 && n < 40000) begin
      @(posedge clk); #1;
      core_bsy = ($urandom_range(0, 9) < 3);
      w = int'(wr_addr) + int'($urandom_range(0, 3));
      wr_addr = AW'((w > 784) ? 784 : w);
      n++;
    end
    chk("frame_done_seen", fd_cnt, 1);
    core_bsy = 0;
    repeat (30) @(negedge clk);
    chk("strt_count", strt_cnt, 676);
    chk("frame_done_count", fd_cnt, 1);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
